// File: rtl/apu_result_queue.sv
// Purpose: APU scalar-result path; builds VL / vs2-element / scalar results and queues them for the core.
// Latency: a result pushed at edge N is presented on apu_rvalid_o/apu_result_o from cycle N+1; outputs are register-driven only.
// Backpressure: req_ready_o drops while the FIFO is full (no bypass); resp_ready_i low holds the head stable.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   req_valid_i / req_ready_o  request handshake; push on valid & ready
//   req_src_i                  0=VL, 1=vs2 element, 2=scalar, 3=zero
//   req_vsew_i                 element width 0=8b, 1=16b, 2=32b, 3=reserved
//   req_idx_i                  element index into vs2_data_i
//   req_unsigned_i             1=zero-extend element, 0=sign-extend
//   req_vl_i                   updated VL value
//   vs2_data_i                 vs2 register contents
//   scalar_i                   scalar passthrough operand
//   resp_ready_i               core consumes the head this cycle
//   apu_rvalid_o               head result valid (FIFO not empty)
//   apu_result_o / apu_flags_o head result and flags ([0] index out of range, [1] reserved vsew)
//   count_o                    FIFO occupancy
//   halt_o                     stall request to core, asserted while full
module apu_result_queue #(
  parameter  int VLEN  = 128,
  parameter  int DEPTH = 2,
  localparam int VLW   = $clog2(VLEN/8) + 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_src_i,
  input  logic [1:0]      req_vsew_i,
  input  logic [VLW-2:0]  req_idx_i,
  input  logic            req_unsigned_i,
  input  logic [VLW-1:0]  req_vl_i,
  input  logic [VLEN-1:0] vs2_data_i,
  input  logic [31:0]     scalar_i,
  input  logic            resp_ready_i,
  output logic            apu_rvalid_o,
  output logic [31:0]     apu_result_o,
  output logic [4:0]      apu_flags_o,
  output logic [CW-1:0]   count_o,
  output logic            halt_o
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Bit offset idx*W is at most (VLEN/8-1)*32 < 4*VLEN.
  localparam int SHW = $clog2(VLEN) + 3;

  typedef struct packed {
    logic [4:0]  flags;
    logic [31:0] result;
  } entry_t;

  entry_t          new_ent;
  logic [SHW-1:0]  sh_amt;
  logic [31:0]     elem;
  logic            in_range;
  logic            sx;

  // Result formation from the request inputs at push time.
  always_comb begin
    new_ent  = '0;
    sh_amt   = SHW'(req_idx_i) << (3 + req_vsew_i);
    elem     = 32'(vs2_data_i >> sh_amt);
    // idx*W < VLEN is equivalent to idx < VLEN/W since W divides VLEN.
    in_range = (sh_amt < SHW'(VLEN));
    sx       = ~req_unsigned_i;
    case (req_src_i)
      2'd0: new_ent.result[VLW-1:0] = req_vl_i;
      2'd2: new_ent.result = scalar_i;
      2'd3: new_ent.result = '0;
      default: begin
        if (req_vsew_i == 2'd3) begin
          new_ent.flags[1] = 1'b1;
        end else if (!in_range) begin
          new_ent.flags[0] = 1'b1;
        end else begin
          case (req_vsew_i)
            2'd0:    new_ent.result = {{24{sx & elem[7]}},  elem[7:0]};
            2'd1:    new_ent.result = {{16{sx & elem[15]}}, elem[15:0]};
            default: new_ent.result = elem;
          endcase
        end
      end
    endcase
  end

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = req_valid_i & ~full;
  assign pop   = ~empty & resp_ready_i;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_ent;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  entry_t head;
  assign head         = mem[rd_ptr];
  assign req_ready_o  = ~full;
  assign halt_o       = full;
  assign count_o      = count;
  assign apu_rvalid_o = ~empty;
  assign apu_result_o = empty ? '0 : head.result;
  assign apu_flags_o  = empty ? '0 : head.flags;

endmodule

// File: tb/tb_apu_result_queue.sv
module tb_apu_result_queue;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [1:0]   req_src = '0;
  logic [1:0]   req_vsew = '0;
  logic [3:0]   req_idx = '0;
  logic         req_uns = 1'b0;
  logic [4:0]   req_vl = '0;
  logic [127:0] vs2 = '0;
  logic [31:0]  scalar = '0;
  logic         resp_ready = 1'b1;

  logic         rdy2, rv2, halt2, rdy3, rv3, halt3;
  logic [31:0]  res2, res3;
  logic [4:0]   fl2, fl3;
  logic [1:0]   cnt2, cnt3;

  apu_result_queue #(.VLEN(128), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy2),
    .req_src_i(req_src), .req_vsew_i(req_vsew), .req_idx_i(req_idx),
    .req_unsigned_i(req_uns), .req_vl_i(req_vl), .vs2_data_i(vs2),
    .scalar_i(scalar), .resp_ready_i(resp_ready), .apu_rvalid_o(rv2),
    .apu_result_o(res2), .apu_flags_o(fl2), .count_o(cnt2), .halt_o(halt2));

  apu_result_queue #(.VLEN(128), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(rdy3),
    .req_src_i(req_src), .req_vsew_i(req_vsew), .req_idx_i(req_idx),
    .req_unsigned_i(req_uns), .req_vl_i(req_vl), .vs2_data_i(vs2),
    .scalar_i(scalar), .resp_ready_i(resp_ready), .apu_rvalid_o(rv3),
    .apu_result_o(res3), .apu_flags_o(fl3), .count_o(cnt3), .halt_o(halt3));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {flags,result} straight from the result rules.
  function automatic logic [36:0] model_res(input logic [1:0] src, input logic [1:0] vsew,
                                            input logic [3:0] idx, input logic uns,
                                            input logic [4:0] vl, input logic [127:0] v,
                                            input logic [31:0] sc);
    int w;
    logic [31:0] e, mask;
    case (src)
      2'd0: return {5'd0, 27'd0, vl};
      2'd2: return {5'd0, sc};
      2'd3: return 37'd0;
      default: begin
        if (vsew == 2'd3) return {5'b00010, 32'd0};
        w = 8 << vsew;
        if (int'(idx) >= 128 / w) return {5'b00001, 32'd0};
        e = 32'(v >> (int'(idx) * w));
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        e = e & mask;
        if (!uns && e[w-1]) e = e | ~mask;
        return {5'd0, e};
      end
    endcase
  endfunction

  logic [36:0] q2[$];
  logic [36:0] q3[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q2.delete();
      q3.delete();
    end else begin
      logic [36:0] v;
      bit pu2, po2, pu3, po3;
      v   = model_res(req_src, req_vsew, req_idx, req_uns, req_vl, vs2, scalar);
      po2 = (q2.size() > 0) && resp_ready;
      pu2 = req_valid && (q2.size() < 2);
      po3 = (q3.size() > 0) && resp_ready;
      pu3 = req_valid && (q3.size() < 3);
      if (po2) void'(q2.pop_front());
      if (pu2) q2.push_back(v);
      if (po3) void'(q3.pop_front());
      if (pu3) q3.push_back(v);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [36:0] h2, h3;
      h2 = (q2.size() > 0) ? q2[0] : 37'd0;
      h3 = (q3.size() > 0) ? q3[0] : 37'd0;
      chk("d2_rvalid", 32'(rv2),   32'(q2.size() != 0));
      chk("d2_result", res2,       h2[31:0]);
      chk("d2_flags",  32'(fl2),   32'(h2[36:32]));
      chk("d2_count",  32'(cnt2),  32'(q2.size()));
      chk("d2_ready",  32'(rdy2),  32'(q2.size() < 2));
      chk("d2_halt",   32'(halt2), 32'(q2.size() == 2));
      chk("d3_rvalid", 32'(rv3),   32'(q3.size() != 0));
      chk("d3_result", res3,       h3[31:0]);
      chk("d3_flags",  32'(fl3),   32'(h3[36:32]));
      chk("d3_count",  32'(cnt3),  32'(q3.size()));
      chk("d3_ready",  32'(rdy3),  32'(q3.size() < 3));
      chk("d3_halt",   32'(halt3), 32'(q3.size() == 3));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_chk(input string name, input logic [1:0] src, input logic [1:0] vsew,
                          input logic [3:0] idx, input logic uns, input logic [4:0] vl,
                          input logic [31:0] sc, input logic [31:0] exp_res,
                          input logic [4:0] exp_fl);
    req_src = src; req_vsew = vsew; req_idx = idx; req_uns = uns;
    req_vl = vl; scalar = sc; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({name, "_rvalid"}, 32'(rv2), 32'd1);
    chk({name, "_res"},    res2, exp_res);
    chk({name, "_flags"},  32'(fl2), 32'(exp_fl));
  endtask

  initial begin
    logic [36:0] m;
    vs2 = (128'h1234 << 112) | (128'h80 << 40);

    // Pin the model against hand-computed values.
    m = model_res(2'd1, 2'd0, 4'd5, 1'b0, 5'd0, vs2, 32'd0);
    chk("pin_byte_s", m[31:0], 32'hFFFF_FF80);
    m = model_res(2'd1, 2'd1, 4'd7, 1'b1, 5'd0, vs2, 32'd0);
    chk("pin_half7", m[31:0], 32'h0000_1234);
    m = model_res(2'd1, 2'd2, 4'd4, 1'b0, 5'd0, vs2, 32'd0);
    chk("pin_oor", 32'(m[36:32]), 32'd1);

    // Reset then idle.
    tick(); tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_rvalid", 32'(rv2), 32'd0);
      chk("idle_result", res2, 32'd0);
      chk("idle_ready", 32'(rdy2), 32'd1);
      chk("idle_count", 32'(cnt2), 32'd0);
    end

    // VL return, one cycle only with resp_ready high.
    resp_ready = 1'b1;
    push_chk("vl16", 2'd0, 2'd0, 4'd0, 1'b0, 5'd16, 32'd0, 32'h10, 5'd0);
    tick();
    chk("vl16_gone", 32'(rv2), 32'd0);

    // Element extraction and error flags.
    push_chk("byte_s",  2'd1, 2'd0, 4'd5, 1'b0, 5'd0, 32'd0, 32'hFFFF_FF80, 5'd0);
    push_chk("byte_u",  2'd1, 2'd0, 4'd5, 1'b1, 5'd0, 32'd0, 32'h0000_0080, 5'd0);
    push_chk("half7",   2'd1, 2'd1, 4'd7, 1'b0, 5'd0, 32'd0, 32'h0000_1234, 5'd0);
    push_chk("half2_s", 2'd1, 2'd1, 4'd2, 1'b0, 5'd0, 32'd0, 32'hFFFF_8000, 5'd0);
    push_chk("word3",   2'd1, 2'd2, 4'd3, 1'b0, 5'd0, 32'd0, 32'h1234_0000, 5'd0);
    push_chk("oor",     2'd1, 2'd2, 4'd4, 1'b0, 5'd0, 32'd0, 32'd0, 5'b00001);
    push_chk("vsew3",   2'd1, 2'd3, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'b00010);
    push_chk("scalar",  2'd2, 2'd0, 4'd0, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd0);
    push_chk("zero",    2'd3, 2'd1, 4'd9, 1'b0, 5'd7, 32'hDEAD_BEEF, 32'd0, 5'd0);
    tick();

    // Fill with backpressure.
    resp_ready = 1'b0;
    req_src = 2'd2; req_valid = 1'b1; scalar = 32'hA;
    tick();
    scalar = 32'hB;
    tick();
    req_valid = 1'b0;
    chk("full_ready", 32'(rdy2), 32'd0);
    chk("full_halt", 32'(halt2), 32'd1);
    chk("full_count", 32'(cnt2), 32'd2);
    chk("full_head", res2, 32'hA);
    scalar = 32'hC; req_valid = 1'b1;   // rejected by depth-2, taken by depth-3
    tick();
    req_valid = 1'b0;
    chk("full_reject_count", 32'(cnt2), 32'd2);
    chk("d3_full_count", 32'(cnt3), 32'd3);
    tick(); tick();
    chk("hold_head", res2, 32'hA);
    chk("hold_rvalid", 32'(rv2), 32'd1);
    resp_ready = 1'b1;
    tick();
    chk("release_b", res2, 32'hB);
    chk("release_ready", 32'(rdy2), 32'd1);
    tick();
    chk("release_empty", 32'(rv2), 32'd0);
    chk("d3_release_c", res3, 32'hC);
    tick();

    // Reset with two entries queued.
    resp_ready = 1'b0;
    req_valid = 1'b1; scalar = 32'h11;
    tick();
    scalar = 32'h22;
    tick();
    req_valid = 1'b0;
    chk("pre_reset_count", 32'(cnt2), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rst_rvalid", 32'(rv2), 32'd0);
    chk("rst_count", 32'(cnt2), 32'd0);
    chk("rst_result", res2, 32'd0);
    chk("rst_ready", 32'(rdy2), 32'd1);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Push and pop together at count 1.
    req_valid = 1'b1; scalar = 32'd1;
    tick();
    chk("pp_start_count", 32'(cnt2), 32'd1);
    resp_ready = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      scalar = 32'(i);
      tick();
      chk("pp_count", 32'(cnt2), 32'd1);
      chk("pp_result", res2, 32'(i));
      chk("pp_d3_count", 32'(cnt3), 32'd1);
      chk("pp_d3_result", res3, 32'(i));
    end
    req_valid = 1'b0;
    tick();
    chk("pp_drained", 32'(rv2), 32'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
